spi_txn_scheduler: RTL and testbench

Round-robin scheduler that shares the SPI controller's register port among `NUM_REQ` requesters. Each granted request becomes one single-transaction SPI job, sequenced entirely on the register bus:
- write address register 0 (0x00) and data register 0 (0x10);
- write control register 0x20 with `8'b0_000_000_1`;
- poll 0x20 until bit 0 clears;
- read back 0x10 for the MISO byte.

The block sits between the requesters and the SPI controller's pclk-domain register interface and is the only bus master on it.

---
 rtl/spi_txn_scheduler_if.sv | 22 ++
 rtl/spi_txn_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_spi_txn_scheduler.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_txn_scheduler_if.sv
// Register-bus link between the transaction scheduler (master) and the
// SPI controller's pclk-domain register port (slave).
interface spi_txn_scheduler_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] paddr;
  logic [WIDTH-1:0] pwdata;
  logic             pwr_rd;
  logic             penable;
  logic [WIDTH-1:0] prdata;
  logic             pready;

  modport master (
    output paddr, pwdata, pwr_rd, penable,
    input  prdata, pready
  );

  modport slave (
    input  paddr, pwdata, pwr_rd, penable,
    output prdata, pready
  );
endinterface

// File: rtl/spi_txn_scheduler.sv
// Round-robin arbiter that turns each granted request into one SPI job
// (addr/data/ctrl writes, busy poll, MISO read-back) on the register bus.
module spi_txn_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned POLL_MAX = 255
) (
  input  logic                     pclk,
  input  logic                     prst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [WIDTH-1:0]         rsp_rdata,
  output logic                     rsp_err,
  spi_txn_scheduler_if.master      bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(POLL_MAX + 1);

  localparam logic [WIDTH-1:0] REG_ADDR = WIDTH'(8'h00);
  localparam logic [WIDTH-1:0] REG_DATA = WIDTH'(8'h10);
  localparam logic [WIDTH-1:0] REG_CTRL = WIDTH'(8'h20);
  localparam logic [WIDTH-1:0] CTRL_GO  = WIDTH'(8'b0_000_000_1);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_CTRL, POLL, RD_DATA, ACK
  } state_e;

  state_e             state_q, state_d;
  state_e             nxt_q, nxt_d;
  logic               gap_q, gap_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   paddr_q, paddr_d;
  logic [WIDTH-1:0]   pwdata_q, pwdata_d;
  logic               pwr_rd_q, pwr_rd_d;
  logic               penable_q, penable_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [IDX_W-1:0]   gnt_c;
  logic               gnt_vld_c;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic               start_c;
  state_e             start_st_c;

  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // First pending requester after the last grant, wrapping around.
  always_comb begin : rr_pick
    int unsigned idx;
    gnt_c     = last_q;
    gnt_vld_c = 1'b0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_vld_c && req_valid[IDX_W'(idx)]) begin
        gnt_vld_c = 1'b1;
        gnt_c     = IDX_W'(idx);
      end
    end
  end

  always_comb begin : next_state
    state_d     = state_q;
    nxt_d       = nxt_q;
    gap_d       = gap_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwr_rd_d    = pwr_rd_q;
    penable_d   = penable_q;
    req_ack_d   = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;
    start_c     = 1'b0;
    start_st_c  = IDLE;

    case (state_q)
      IDLE: begin
        if (gnt_vld_c) begin
          last_d     = gnt_c;
          addr_d     = req_addr[32'(gnt_c)*WIDTH +: WIDTH];
          wdata_d    = req_wdata[32'(gnt_c)*WIDTH +: WIDTH];
          state_d    = WR_ADDR;
          start_c    = 1'b1;
          start_st_c = WR_ADDR;
        end
      end
      ACK: begin
        req_ack_d[last_q] = 1'b1;
        rsp_err_d         = err_q;
        err_d             = 1'b0;
        cnt_d             = '0;
        state_d           = IDLE;
      end
      default: begin
        if (gap_q) begin
          // Idle cycle done: move on and launch the next access, if any.
          state_d = nxt_q;
          if (nxt_q != ACK) begin
            start_c    = 1'b1;
            start_st_c = nxt_q;
          end
        end else if (bus.pready) begin
          gap_d     = 1'b1;
          penable_d = 1'b0;
          paddr_d   = '0;
          pwdata_d  = '0;
          pwr_rd_d  = 1'b0;
          case (state_q)
            WR_ADDR: nxt_d = WR_DATA;
            WR_DATA: nxt_d = WR_CTRL;
            WR_CTRL: nxt_d = POLL;
            POLL: begin
              cnt_d = cnt_inc_c;
              if (!bus.prdata[0]) begin
                nxt_d = RD_DATA;
              end else if (cnt_inc_c == CNT_W'(POLL_MAX)) begin
                err_d       = 1'b1;
                rsp_rdata_d = '0;
                nxt_d       = ACK;
              end else begin
                nxt_d = POLL;
              end
            end
            RD_DATA: begin
              rsp_rdata_d = bus.prdata;
              nxt_d       = ACK;
            end
            default: nxt_d = IDLE;
          endcase
        end
      end
    endcase

    // Access launch: bus fields are registered so they are stable from the first cycle.
    if (start_c) begin
      penable_d = 1'b1;
      gap_d     = 1'b0;
      case (start_st_c)
        WR_ADDR: begin paddr_d = REG_ADDR; pwdata_d = addr_d;  pwr_rd_d = 1'b1; end
        WR_DATA: begin paddr_d = REG_DATA; pwdata_d = wdata_d; pwr_rd_d = 1'b1; end
        WR_CTRL: begin paddr_d = REG_CTRL; pwdata_d = CTRL_GO; pwr_rd_d = 1'b1; end
        POLL:    begin paddr_d = REG_CTRL; pwdata_d = '0;      pwr_rd_d = 1'b0; end
        RD_DATA: begin paddr_d = REG_DATA; pwdata_d = '0;      pwr_rd_d = 1'b0; end
        default: begin
          penable_d = 1'b0;
          paddr_d   = '0;
          pwdata_d  = '0;
          pwr_rd_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q     <= IDLE;
      nxt_q       <= IDLE;
      gap_q       <= 1'b0;
      last_q      <= IDX_W'(NUM_REQ - 1);
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwr_rd_q    <= 1'b0;
      penable_q   <= 1'b0;
      req_ack_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      nxt_q       <= nxt_d;
      gap_q       <= gap_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwr_rd_q    <= pwr_rd_d;
      penable_q   <= penable_d;
      req_ack_q   <= req_ack_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.paddr   = paddr_q;
  assign bus.pwdata  = pwdata_q;
  assign bus.pwr_rd  = pwr_rd_q;
  assign bus.penable = penable_q;
  assign req_ack     = req_ack_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_spi_txn_scheduler.sv
// Directed bench for spi_txn_scheduler: register-file slave model, vector
// table for single jobs, hand sequences for round-robin and reset cases.
module tb_spi_txn_scheduler;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned PM = 4;

  logic            pclk      = 1'b0;
  logic            prst      = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*W-1:0] req_addr  = '0;
  logic [NR*W-1:0] req_wdata = '0;
  logic [NR-1:0]   req_ack;
  logic [W-1:0]    rsp_rdata;
  logic            rsp_err;

  spi_txn_scheduler_if #(.WIDTH(W)) bus_if ();

  spi_txn_scheduler #(.NUM_REQ(NR), .WIDTH(W), .POLL_MAX(PM)) dut (
    .pclk      (pclk),
    .prst      (prst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus       (bus_if)
  );

  always #5 pclk = ~pclk;

  typedef struct packed { logic wr; logic [7:0] addr; logic [7:0] data; } acc_t;
  typedef struct { logic [3:0] ack; logic [7:0] rdata; logic err; int cyc; } ack_t;
  typedef struct {
    int idx; logic [7:0] addr; logic [7:0] wdata; logic [7:0] rdval;
    int w; int busy; logic [3:0] exp_ack; logic [7:0] exp_rdata; logic exp_err;
    int exp_polls; int exp_lat;
  } vec_t;

  acc_t log_q[$];
  ack_t ack_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, start_cyc = 0, proto_err = 0;
  bit   in_job = 0;
  int   cfg_wait = 0, cfg_busy = 0, poll_cnt = 0;
  logic [7:0] cfg_rd = '0;
  logic [NR-1:0] rereq = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_acks(input int n, input int budget);
    int t = 0;
    while (ack_q.size() < n && t < budget) begin
      @(posedge pclk); #2; t++;
    end
    n_cmp++;
    if (ack_q.size() < n) begin
      n_bad++;
      $display("FAIL ack_timeout: got %0d acks, want %0d", ack_q.size(), n);
    end
  endtask

  function automatic logic [3:0] ack_at(input int k);
    return (k < ack_q.size()) ? ack_q[k].ack : 4'h0;
  endfunction

  // Slave register model plus ack/protocol monitor, all sampled 1 ns after the edge.
  initial begin : slave_mon
    int   wcnt;
    logic was_en;
    logic [16:0] saved;
    acc_t a;
    wcnt = 0; was_en = 1'b0; saved = '0;
    bus_if.pready = 1'b0;
    bus_if.prdata = '0;
    forever begin
      @(posedge pclk); cyc++; #1;
      if (req_ack != '0) begin
        ack_q.push_back('{req_ack, rsp_rdata, rsp_err, cyc});
        for (int i = 0; i < int'(NR); i++)
          if (req_ack[i]) begin
            if (rereq[i]) rereq[i] = 1'b0;
            else          req_valid[i] = 1'b0;
          end
        in_job = 1'b0;
      end
      if (!bus_if.penable) begin
        if ({bus_if.paddr, bus_if.pwdata, bus_if.pwr_rd} != '0) proto_err++;
        bus_if.pready = 1'b0;
        bus_if.prdata = '0;
        wcnt = 0;
        was_en = 1'b0;
      end else begin
        if (!in_job) begin in_job = 1'b1; start_cyc = cyc; end
        if (was_en && {bus_if.paddr, bus_if.pwdata, bus_if.pwr_rd} != saved) proto_err++;
        saved  = {bus_if.paddr, bus_if.pwdata, bus_if.pwr_rd};
        was_en = 1'b1;
        if (wcnt < cfg_wait) begin
          wcnt++;
          bus_if.pready = 1'b0;
        end else begin
          wcnt = 0;
          a.wr = bus_if.pwr_rd;
          a.addr = bus_if.paddr;
          if (bus_if.pwr_rd) begin
            a.data = bus_if.pwdata;
            if (bus_if.paddr == 8'h20) poll_cnt = 0;
            bus_if.prdata = '0;
          end else begin
            if (bus_if.paddr == 8'h20) begin
              poll_cnt++;
              bus_if.prdata = (poll_cnt <= cfg_busy) ? 8'h01 : 8'h00;
            end else if (bus_if.paddr == 8'h10) bus_if.prdata = cfg_rd;
            else bus_if.prdata = '0;
            a.data = bus_if.prdata;
          end
          log_q.push_back(a);
          bus_if.pready = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs[6];
    acc_t exp_q[$];
    ack_t got;
    int   polls, mism;
    bit   found;
    logic [3:0] rr_exp [5];

    //        idx addr   wdata  rdval  w busy  ack    rdata  err polls lat
    vecs[0] = '{1, 8'hA5, 8'h3C, 8'h5A, 0, 1,    4'b0010, 8'h5A, 1'b0, 2, 13};
    vecs[1] = '{0, 8'h11, 8'h22, 8'hC3, 0, 0,    4'b0001, 8'hC3, 1'b0, 1, 11};
    vecs[2] = '{3, 8'hFF, 8'h00, 8'h81, 0, 3,    4'b1000, 8'h81, 1'b0, 4, 17};
    vecs[3] = '{2, 8'h5C, 8'hE7, 8'h99, 0, 1000, 4'b0100, 8'h00, 1'b1, 4, 15};
    vecs[4] = '{1, 8'h0F, 8'hF0, 8'h42, 3, 2,    4'b0010, 8'h42, 1'b0, 3, 36};
    vecs[5] = '{0, 8'h77, 8'h88, 8'hEE, 1, 1000, 4'b0001, 8'h00, 1'b1, 4, 22};
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    repeat (3) @(posedge pclk);
    #2;
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_bus", 32'({bus_if.penable, bus_if.pwr_rd, bus_if.paddr, bus_if.pwdata}), 0);
    chk("rst_rsp", 32'({rsp_err, rsp_rdata}), 0);
    @(negedge pclk) prst = 1'b1;
    repeat (4) @(posedge pclk);
    #2;
    chk("idle_bus", 32'({bus_if.penable, bus_if.pwr_rd, bus_if.paddr, bus_if.pwdata}), 0);

    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      log_q.delete(); ack_q.delete(); proto_err = 0; in_job = 1'b0;
      cfg_wait = vecs[i].w; cfg_busy = vecs[i].busy; cfg_rd = vecs[i].rdval;
      req_addr[vecs[i].idx*W +: W]  = vecs[i].addr;
      req_wdata[vecs[i].idx*W +: W] = vecs[i].wdata;
      req_valid = 4'(1 << vecs[i].idx);
      wait_acks(1, 300);
      repeat (2) @(posedge pclk);
      #2;
      got = '{4'h0, 8'h00, 1'b0, 0};
      if (ack_q.size() > 0) got = ack_q[0];
      chk($sformatf("v%0d_ack", i), 32'(got.ack), 32'(vecs[i].exp_ack));
      chk($sformatf("v%0d_rdata", i), 32'(got.rdata), 32'(vecs[i].exp_rdata));
      chk($sformatf("v%0d_err", i), 32'(got.err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_nack", i), ack_q.size(), 1);
      chk($sformatf("v%0d_latency", i), got.cyc - start_cyc, vecs[i].exp_lat);
      polls = 0;
      foreach (log_q[j]) if (!log_q[j].wr && log_q[j].addr == 8'h20) polls++;
      chk($sformatf("v%0d_polls", i), polls, vecs[i].exp_polls);
      exp_q.delete();
      exp_q.push_back({1'b1, 8'h00, vecs[i].addr});
      exp_q.push_back({1'b1, 8'h10, vecs[i].wdata});
      exp_q.push_back({1'b1, 8'h20, 8'h01});
      for (int p = 1; p <= vecs[i].exp_polls; p++)
        exp_q.push_back({1'b0, 8'h20, (p <= vecs[i].busy) ? 8'h01 : 8'h00});
      if (!vecs[i].exp_err) exp_q.push_back({1'b0, 8'h10, vecs[i].rdval});
      mism = (log_q.size() != exp_q.size()) ? 1 : 0;
      for (int j = 0; j < exp_q.size() && j < log_q.size(); j++)
        if (log_q[j] != exp_q[j]) mism++;
      chk($sformatf("v%0d_bus_seq", i), mism, 0);
      chk($sformatf("v%0d_protocol", i), proto_err, 0);
    end

    // All four at once after reset; requester 0 re-requests straight after its ack.
    @(negedge pclk) prst = 1'b0;
    repeat (2) @(negedge pclk);
    prst = 1'b1;
    log_q.delete(); ack_q.delete(); proto_err = 0;
    cfg_wait = 0; cfg_busy = 0; cfg_rd = 8'h77;
    for (int i = 0; i < int'(NR); i++) begin
      req_addr[i*W +: W]  = 8'(8'h40 + i);
      req_wdata[i*W +: W] = 8'(8'h50 + i);
    end
    rereq = 4'b0001;
    req_valid = 4'b1111;
    wait_acks(5, 400);
    repeat (2) @(posedge pclk);
    #2;
    for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), 32'(ack_at(k)), 32'(rr_exp[k]));
    chk("rr_regrant_gap", (ack_q.size() > 1) ? ack_q[1].cyc - ack_q[0].cyc : 0, 12);
    chk("rr_rdata", (ack_q.size() > 0) ? 32'(ack_q[0].rdata) : 0, 32'h77);

    // Reset while polling a stuck-busy controller.
    @(negedge pclk);
    ack_q.delete(); cfg_busy = 1000;
    req_valid = 4'b0010;
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(posedge pclk); #2;
      if (bus_if.penable && !bus_if.pwr_rd && bus_if.paddr == 8'h20) found = 1'b1;
    end
    chk("poll_reached", 32'(found), 1);
    prst = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_async_bus", 32'({bus_if.penable, bus_if.pwr_rd, bus_if.paddr, bus_if.pwdata}), 0);
    chk("rst_async_rsp", 32'({req_ack, rsp_err, rsp_rdata}), 0);
    @(negedge pclk);
    @(negedge pclk);
    ack_q.delete(); cfg_busy = 0; cfg_rd = 8'h3E;
    req_valid = 4'b0100;
    prst = 1'b1;
    wait_acks(1, 100);
    repeat (2) @(posedge pclk);
    #2;
    chk("rst_first_ack", 32'(ack_at(0)), 32'b0100);
    chk("rst_no_stale_ack", ack_q.size(), 1);
    chk("rst_rdata", (ack_q.size() > 0) ? 32'(ack_q[0].rdata) : 0, 32'h3E);

    // Leave last_grant at 1, then reset: requester 0 must beat requester 2.
    @(negedge pclk);
    ack_q.delete();
    req_valid = 4'b0010;
    wait_acks(1, 100);
    chk("pre_rst_ack", 32'(ack_at(0)), 32'b0010);
    @(negedge pclk) prst = 1'b0;
    @(negedge pclk);
    ack_q.delete();
    req_valid = 4'b0101;
    @(negedge pclk) prst = 1'b1;
    wait_acks(2, 200);
    repeat (2) @(posedge pclk);
    #2;
    chk("rst_lg_first", 32'(ack_at(0)), 32'b0001);
    chk("rst_lg_second", 32'(ack_at(1)), 32'b0100);
    chk("protocol_all", proto_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
